// File: rtl/minibus_arbiter_if.sv
// Signal bundle between the D/I datapath ports, the arbiter and the minibus slave.
// The master modport is the arbiter's view; slave is the view of everything around it.
interface minibus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              d_ren;
    logic              d_wen;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [1:0]        d_width;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic              i_ren;
    logic [ADDR_W-1:0] i_addr;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;
    logic              i_err;

    logic              bus_ren;
    logic              bus_wen;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [1:0]        bus_width;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_err;

    modport master (
        input  d_ren, d_wen, d_addr, d_wdata, d_width,
        output d_done, d_rdata, d_err,
        input  i_ren, i_addr,
        output i_done, i_rdata, i_err,
        output bus_ren, bus_wen, bus_addr, bus_wdata, bus_width,
        input  bus_ack, bus_rdata, bus_err
    );

    modport slave (
        output d_ren, d_wen, d_addr, d_wdata, d_width,
        input  d_done, d_rdata, d_err,
        output i_ren, i_addr,
        input  i_done, i_rdata, i_err,
        input  bus_ren, bus_wen, bus_addr, bus_wdata, bus_width,
        output bus_ack, bus_rdata, bus_err
    );
endinterface

// File: rtl/minibus_arbiter.sv
// Two-requester minibus arbiter: D has priority, a starvation counter forces I through,
// and a BUSY timer turns a missing ack into an error completion.
//
//  state | meaning
//  IDLE  | sample requests, latch the winner into the bus registers
//  BUSY  | strobes held, waiting for bus_ack or timeout
//  RESP  | one-cycle done pulse to the owner
module minibus_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int TIMEOUT      = 256,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    minibus_arbiter_if.master   mb
);
    localparam int TW = $clog2(TIMEOUT);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t          state;
    logic            owner_i;
    logic [TW-1:0]   timer;
    logic [SW-1:0]   starve;

    logic              pick_i;
    logic              pick_d;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
    logic              busy_end;

    always_comb begin
        pick_i = 1'b0;
        pick_d = 1'b0;
        if (mb.i_ren && starve == SMAX)
            pick_i = 1'b1;
        else if (mb.d_ren || mb.d_wen)
            pick_d = 1'b1;
        else if (mb.i_ren)
            pick_i = 1'b1;
    end

    // Ack wins over a coinciding timeout; timeout completes with zero data and error.
    always_comb begin
        busy_end   = mb.bus_ack || (timer == TMAX);
        resp_rdata = '0;
        resp_err   = 1'b1;
        if (mb.bus_ack) begin
            resp_rdata = mb.bus_wen ? '0 : mb.bus_rdata;
            resp_err   = mb.bus_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            owner_i      <= 1'b0;
            timer        <= '0;
            starve       <= '0;
            mb.bus_ren   <= 1'b0;
            mb.bus_wen   <= 1'b0;
            mb.bus_addr  <= '0;
            mb.bus_wdata <= '0;
            mb.bus_width <= 2'b00;
            mb.d_done    <= 1'b0;
            mb.d_rdata   <= '0;
            mb.d_err     <= 1'b0;
            mb.i_done    <= 1'b0;
            mb.i_rdata   <= '0;
            mb.i_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_i) begin
                        owner_i      <= 1'b1;
                        mb.bus_ren   <= 1'b1;
                        mb.bus_wen   <= 1'b0;
                        mb.bus_addr  <= mb.i_addr;
                        mb.bus_wdata <= '0;
                        mb.bus_width <= 2'b10;
                        starve       <= '0;
                        timer        <= '0;
                        state        <= BUSY;
                    end else if (pick_d) begin
                        owner_i      <= 1'b0;
                        mb.bus_ren   <= ~mb.d_wen;
                        mb.bus_wen   <= mb.d_wen;
                        mb.bus_addr  <= mb.d_addr;
                        mb.bus_wdata <= mb.d_wen ? mb.d_wdata : '0;
                        mb.bus_width <= mb.d_width;
                        if (!mb.i_ren)
                            starve <= '0;
                        else if (starve != SMAX)
                            starve <= starve + SW'(1);
                        timer        <= '0;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    timer <= timer + TW'(1);
                    if (busy_end) begin
                        mb.bus_ren <= 1'b0;
                        mb.bus_wen <= 1'b0;
                        mb.d_done  <= ~owner_i;
                        mb.d_rdata <= owner_i ? '0 : resp_rdata;
                        mb.d_err   <= ~owner_i & resp_err;
                        mb.i_done  <= owner_i;
                        mb.i_rdata <= owner_i ? resp_rdata : '0;
                        mb.i_err   <= owner_i & resp_err;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    mb.d_done  <= 1'b0;
                    mb.d_rdata <= '0;
                    mb.d_err   <= 1'b0;
                    mb.i_done  <= 1'b0;
                    mb.i_rdata <= '0;
                    mb.i_err   <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_minibus_arbiter.sv
// Directed bench for minibus_arbiter with TIMEOUT=8 and STARVE_LIMIT=4.
module tb_minibus_arbiter;
    localparam logic [31:0] D_ADDR = 32'h0000_3000;
    localparam logic [31:0] I_ADDR = 32'h0000_0400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    minibus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mb ();

    minibus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .STARVE_LIMIT(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mb  (mb)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " bus_ren"}, 32'(mb.bus_ren), 32'd0);
        check({tag, " bus_wen"}, 32'(mb.bus_wen), 32'd0);
        check({tag, " d_done"},  32'(mb.d_done),  32'd0);
        check({tag, " i_done"},  32'(mb.i_done),  32'd0);
        check({tag, " d_rdata"}, mb.d_rdata,      32'd0);
        check({tag, " i_rdata"}, mb.i_rdata,      32'd0);
        check({tag, " d_err"},   32'(mb.d_err),   32'd0);
        check({tag, " i_err"},   32'(mb.i_err),   32'd0);
    endtask

    // Starts in IDLE with requests set; acks in the first BUSY cycle; returns in the next IDLE.
    task automatic grant(input bit exp_i, input string tag);
        logic [31:0] rd;
        rd = exp_i ? 32'h1111_0000 : 32'h0000_2222;
        tick();
        check({tag, " bus_ren"},  32'(mb.bus_ren), 32'd1);
        check({tag, " bus_addr"}, mb.bus_addr, exp_i ? I_ADDR : D_ADDR);
        check({tag, " bus_width"}, 32'(mb.bus_width), exp_i ? 32'd2 : 32'd1);
        mb.bus_ack   = 1'b1;
        mb.bus_rdata = rd;
        tick();
        mb.bus_ack   = 1'b0;
        mb.bus_rdata = '0;
        check({tag, " d_done"},  32'(mb.d_done), exp_i ? 32'd0 : 32'd1);
        check({tag, " i_done"},  32'(mb.i_done), exp_i ? 32'd1 : 32'd0);
        check({tag, " d_rdata"}, mb.d_rdata, exp_i ? 32'd0 : rd);
        check({tag, " i_rdata"}, mb.i_rdata, exp_i ? rd : 32'd0);
        tick();
    endtask

    initial begin
        mb.d_ren = 0; mb.d_wen = 0; mb.d_addr = '0; mb.d_wdata = '0; mb.d_width = 2'b00;
        mb.i_ren = 0; mb.i_addr = '0;
        mb.bus_ack = 0; mb.bus_rdata = '0; mb.bus_err = 0;

        tick(); tick();
        check_quiet("reset");
        check("reset bus_addr",  mb.bus_addr,  32'd0);
        check("reset bus_wdata", mb.bus_wdata, 32'd0);
        rst = 1'b0;
        tick();

        // I fetch alone, ack in cycle 3
        mb.i_ren = 1; mb.i_addr = 32'h100;
        tick();
        check("t1 c1 bus_ren",   32'(mb.bus_ren),   32'd1);
        check("t1 c1 bus_wen",   32'(mb.bus_wen),   32'd0);
        check("t1 c1 bus_addr",  mb.bus_addr,       32'h100);
        check("t1 c1 bus_width", 32'(mb.bus_width), 32'd2);
        check("t1 c1 bus_wdata", mb.bus_wdata,      32'd0);
        tick();
        check("t1 c2 bus_ren", 32'(mb.bus_ren), 32'd1);
        check("t1 c2 i_done",  32'(mb.i_done),  32'd0);
        tick();
        check("t1 c3 bus_ren", 32'(mb.bus_ren), 32'd1);
        mb.bus_ack = 1; mb.bus_rdata = 32'hDEADBEEF;
        tick();
        mb.bus_ack = 0; mb.bus_rdata = '0; mb.i_ren = 0;
        check("t1 c4 i_done",  32'(mb.i_done),  32'd1);
        check("t1 c4 i_rdata", mb.i_rdata,      32'hDEADBEEF);
        check("t1 c4 i_err",   32'(mb.i_err),   32'd0);
        check("t1 c4 d_done",  32'(mb.d_done),  32'd0);
        check("t1 c4 bus_ren", 32'(mb.bus_ren), 32'd0);
        tick();
        check_quiet("t1 c5");

        // D store alone, d_ren also high so the write must win
        mb.d_wen = 1; mb.d_ren = 1; mb.d_addr = 32'h2000; mb.d_wdata = 32'h55AA55AA; mb.d_width = 2'd2;
        tick();
        check("t2 bus_wen",   32'(mb.bus_wen),   32'd1);
        check("t2 bus_ren",   32'(mb.bus_ren),   32'd0);
        check("t2 bus_addr",  mb.bus_addr,       32'h2000);
        check("t2 bus_wdata", mb.bus_wdata,      32'h55AA55AA);
        check("t2 bus_width", 32'(mb.bus_width), 32'd2);
        mb.bus_ack = 1; mb.bus_rdata = 32'hFFFFFFFF;
        tick();
        mb.bus_ack = 0; mb.bus_rdata = '0; mb.d_wen = 0; mb.d_ren = 0;
        check("t2 d_done",  32'(mb.d_done), 32'd1);
        check("t2 d_rdata", mb.d_rdata,     32'd0);
        check("t2 d_err",   32'(mb.d_err),  32'd0);
        check("t2 i_done",  32'(mb.i_done), 32'd0);
        tick();

        // Simultaneous D and I: D first, then I right after D's RESP
        mb.d_addr = D_ADDR; mb.d_width = 2'd1; mb.i_addr = I_ADDR;
        mb.d_ren = 1; mb.i_ren = 1;
        grant(1'b0, "t3 D");
        mb.d_ren = 0;
        grant(1'b1, "t3 I");
        mb.i_ren = 0;
        check_quiet("t3 idle");

        // Starvation: four D grants, one forced I, then D again
        mb.d_ren = 1; mb.i_ren = 1;
        for (int k = 0; k < 4; k++) grant(1'b0, $sformatf("t4 D%0d", k));
        grant(1'b1, "t4 I");
        mb.i_ren = 0;
        grant(1'b0, "t4 D resume");
        mb.d_ren = 0;
        tick();
        check_quiet("t4 idle");

        // Timeout: strobes held 8 cycles, error completion, late ack ignored
        mb.d_ren = 1; mb.d_addr = 32'h5000;
        for (int c = 1; c <= 8; c++) begin
            tick();
            check($sformatf("t5 c%0d bus_ren", c), 32'(mb.bus_ren), 32'd1);
        end
        tick();
        mb.d_ren = 0;
        check("t5 d_done",  32'(mb.d_done),  32'd1);
        check("t5 d_err",   32'(mb.d_err),   32'd1);
        check("t5 d_rdata", mb.d_rdata,      32'd0);
        check("t5 bus_ren", 32'(mb.bus_ren), 32'd0);
        mb.bus_ack = 1; mb.bus_rdata = 32'hABCD0000;
        tick();
        check_quiet("t5 late ack idle");
        tick();
        mb.bus_ack = 0; mb.bus_rdata = '0;
        check_quiet("t5 after late ack");

        // Reset during BUSY
        mb.d_wen = 1; mb.d_addr = 32'h6000; mb.d_wdata = 32'h12345678;
        tick();
        check("t6 busy bus_wen", 32'(mb.bus_wen), 32'd1);
        rst = 1;
        tick();
        rst = 0; mb.d_wen = 0;
        check_quiet("t6 reset");
        check("t6 reset bus_addr",  mb.bus_addr,  32'd0);
        check("t6 reset bus_wdata", mb.bus_wdata, 32'd0);
        tick();
        check_quiet("t6 idle");

        // Slave error on an I fetch
        mb.i_ren = 1; mb.i_addr = 32'h700;
        tick();
        check("t6 err bus_ren", 32'(mb.bus_ren), 32'd1);
        mb.bus_ack = 1; mb.bus_err = 1; mb.bus_rdata = 32'h1234;
        tick();
        mb.bus_ack = 0; mb.bus_err = 0; mb.bus_rdata = '0; mb.i_ren = 0;
        check("t6 err i_done",  32'(mb.i_done), 32'd1);
        check("t6 err i_err",   32'(mb.i_err),  32'd1);
        check("t6 err i_rdata", mb.i_rdata,     32'h1234);
        check("t6 err d_done",  32'(mb.d_done), 32'd0);
        tick();
        check_quiet("t6 end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
